// File: rtl/fifo_22to64_ctrl_pkg.sv
// fifo_22to64_ctrl_pkg: widths and state encoding shared by the packer-controller slice
package fifo_22to64_ctrl_pkg;
  localparam int REC_W = 22;
  localparam int WORD_W = 64;
  localparam int LVL_W = 2;
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_PAD = 2'd1, ST_SHORT = 2'd2} state_t;
endpackage

// File: rtl/fifo_22to64_ctrl_rr_arbiter.sv
// fifo_22to64_ctrl_rr_arbiter: combinational round-robin arbiter, priority starts at ptr
module fifo_22to64_ctrl_rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  always_comb begin
    int j;
    grant = '0;
    idx = '0;
    j = 0;
    // walk from the farthest offset down so the requester nearest ptr wins
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        grant = N'(1) << j;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/fifo_22to64_ctrl.sv
// fifo_22to64_ctrl: arbitrates producers onto the 22-to-64 packer and sequences partial-word flushes
module fifo_22to64_ctrl
  import fifo_22to64_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDLE_CYCLES = 16,
  parameter logic [REC_W-1:0] PAD_WORD = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*REC_W-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [REC_W-1:0]     pk_a_data,
  output logic                 pk_a_valid,
  input  logic                 pk_a_ready,
  output logic                 pk_short,
  input  logic                 pk_b_valid,
  input  logic                 pk_b_ready,
  output logic [LVL_W-1:0]     level_o,
  output logic                 busy
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(IDLE_CYCLES + 1);

  state_t state;
  logic [LVL_W-1:0] level, lvl_nx;
  logic [IW-1:0] rr_ptr, idx;
  logic [CW-1:0] idle_cnt;
  logic flush_pend;
  logic [NREQ-1:0] grant;
  logic run, pad, a_hs, b_hs, full, idle_hit, trig;

  fifo_22to64_ctrl_rr_arbiter #(.N(NREQ)) u_arb (
    .req(flush_pend ? '0 : req_valid),
    .ptr(rr_ptr),
    .grant(grant),
    .idx(idx)
  );

  assign run = state == ST_RUN;
  assign pad = state == ST_PAD;
  // combinational outputs are gated by rst_n so they drop the moment reset asserts
  assign pk_a_valid = rst_n & (pad | (run & |grant));
  assign pk_a_data = pad ? PAD_WORD : req_data[REC_W*idx +: REC_W];
  assign req_ready = (rst_n & run & pk_a_ready) ? grant : '0;
  assign a_hs = pk_a_valid & pk_a_ready;
  assign b_hs = pk_b_valid & pk_b_ready;
  assign full = pk_short ? level == 2'd2 : level == 2'd3;
  assign lvl_nx = full ? (b_hs ? {1'b0, a_hs} : level) : (a_hs ? level + 2'd1 : level);
  assign idle_hit = idle_cnt == CW'(IDLE_CYCLES);
  assign trig = flush_pend | idle_hit;
  assign busy = !run | flush_pend;
  assign level_o = level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      level <= '0;
      rr_ptr <= '0;
      idle_cnt <= '0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
      pk_short <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      level <= lvl_nx;
      if (!flush_pend && flush_req) flush_pend <= 1'b1;
      idle_cnt <= (a_hs || level == '0) ? '0 : (run && !idle_hit) ? idle_cnt + CW'(1) : idle_cnt;
      if (run && a_hs) rr_ptr <= (idx == IW'(NREQ - 1)) ? '0 : idx + IW'(1);
      // a record accepted this cycle restarts the idle window, so it takes precedence over the trigger
      if (run) begin
        if (trig && !a_hs) begin
          if (level == 2'd0 && flush_pend) begin
            flush_done <= 1'b1;
            flush_pend <= 1'b0;
          end else if (level == 2'd1) begin
            state <= ST_PAD;
          end else if (level == 2'd2) begin
            state <= ST_SHORT;
            pk_short <= 1'b1;
          end
        end
      end else if (pad) begin
        if (a_hs) begin
          state <= ST_SHORT;
          pk_short <= 1'b1;
        end
      end else if (b_hs) begin
        state <= ST_RUN;
        pk_short <= 1'b0;
        idle_cnt <= '0;
        if (flush_pend) begin
          flush_done <= 1'b1;
          flush_pend <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_fifo_22to64_ctrl.sv
// tb_fifo_22to64_ctrl: random and directed stimulus against a queue-based packer/controller model
module tb_fifo_22to64_ctrl;
  localparam int N = 4;
  localparam int IDLE = 16;
  localparam logic [21:0] PAD = 22'h0;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*22-1:0] req_data = '0;
  logic flush_req = 1'b0, flush_done;
  logic [21:0] pk_a_data;
  logic pk_a_valid, pk_a_ready = 1'b1, pk_short, pk_b_valid = 1'b0, pk_b_ready = 1'b1;
  logic [1:0] level_o;
  logic busy;

  always #5 clk = ~clk;

  fifo_22to64_ctrl #(.NREQ(N), .IDLE_CYCLES(IDLE), .PAD_WORD(PAD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .flush_req(flush_req), .flush_done(flush_done), .pk_a_data(pk_a_data), .pk_a_valid(pk_a_valid),
    .pk_a_ready(pk_a_ready), .pk_short(pk_short), .pk_b_valid(pk_b_valid), .pk_b_ready(pk_b_ready),
    .level_o(level_o), .busy(busy)
  );

  int m_mode, m_rr, m_idle;
  bit m_pend, m_done;
  logic [21:0] pq[$];
  int n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit m_full();
    return (m_mode == 2) ? pq.size() == 2 : pq.size() == 3;
  endfunction

  task automatic m_reset();
    m_mode = 0; m_rr = 0; m_idle = 0; m_pend = 0; m_done = 0;
    pq.delete();
  endtask

  task automatic cycle(input logic [N-1:0] v, input bit fr, input bit br);
    int g, sz, oi;
    bit ea, a, b, full, op;
    logic [21:0] d;
    @(negedge clk);
    req_valid = v;
    flush_req = fr;
    pk_b_ready = br;
    for (int i = 0; i < N; i++) req_data[22*i +: 22] = 22'($urandom);
    full = m_full();
    pk_b_valid = full;
    pk_a_ready = !full || br;
    g = -1;
    if (m_mode == 0 && !m_pend)
      for (int k = N - 1; k >= 0; k--) if (v[(m_rr + k) % N]) g = (m_rr + k) % N;
    ea = (m_mode == 1) || g >= 0;
    d = PAD;
    if (m_mode == 0 && g >= 0) d = req_data[22*g +: 22];
    #1;
    check("a_valid", 32'(pk_a_valid), 32'(ea));
    if (ea) check("a_data", 32'(pk_a_data), 32'(d));
    check("req_ready", 32'(req_ready), (g >= 0 && pk_a_ready) ? 32'(1) << g : 32'(0));
    check("short", 32'(pk_short), 32'(m_mode == 2));
    check("level", 32'(level_o), 32'(pq.size()));
    check("busy", 32'(busy), 32'(m_mode != 0 || m_pend));
    check("done", 32'(flush_done), 32'(m_done));
    a = ea && pk_a_ready;
    b = full && br;
    sz = pq.size();
    op = m_pend;
    oi = m_idle;
    m_done = 0;
    if (!op && fr) m_pend = 1;
    if (a || sz == 0) m_idle = 0;
    else if (m_mode == 0 && m_idle < IDLE) m_idle++;
    if (m_mode == 0 && a) m_rr = (g + 1) % N;
    if (full && b) pq.delete();
    if (a && (!full || b)) pq.push_back(d);
    case (m_mode)
      0: if ((op || oi == IDLE) && !a) begin
           if (sz == 0 && op) begin m_done = 1; m_pend = 0; end
           else if (sz == 1) m_mode = 1;
           else if (sz == 2) m_mode = 2;
         end
      1: if (a) m_mode = 2;
      default: if (b) begin
           m_mode = 0;
           m_idle = 0;
           if (op) begin m_done = 1; m_pend = 0; end
         end
    endcase
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) cycle('1, 0, 1);
    cycle(4'b0001, 0, 1);
    repeat (30) cycle('0, 0, 1);
    repeat (2) cycle(4'b0100, 0, 1);
    cycle('0, 1, 1);
    repeat (10) cycle('0, 0, 1);
    repeat (6) cycle('1, 0, 0);
    cycle('1, 1, 0);
    repeat (5) cycle('1, 0, 0);
    repeat (5) cycle('0, 0, 1);
    repeat (20) cycle('0, 0, 1);
    cycle('0, 1, 1);
    cycle('0, 1, 1);
    repeat (5) cycle('0, 0, 1);
    repeat (2) cycle(4'b0010, 0, 1);
    cycle('0, 1, 0);
    repeat (4) cycle('0, 0, 0);
    check("pre_rst_short", 32'(pk_short), 32'(m_mode == 2));
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    check("rst_a_valid", 32'(pk_a_valid), 32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(0));
    check("rst_short", 32'(pk_short), 32'(0));
    check("rst_level", 32'(level_o), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(flush_done), 32'(0));
    m_reset();
    pk_a_ready = 1'b1;
    pk_b_valid = 1'b0;
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    cycle('1, 0, 1);
    repeat (2000) cycle(N'($urandom), $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
